// File: rtl/uart_pkg.sv
// Shared definitions for the UART responder: FSM state encoding, register
// offsets and status bit positions (also consumed by the bridge).
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam logic [3:0] UART_DATA_OFF = 4'h8;
  localparam logic [3:0] UART_STAT_OFF = 4'hc;

  localparam int TX_READY_BIT = 0;
  localparam int RX_READY_BIT = 1;

endpackage

// File: rtl/uart_rx_core.sv
// UART receiver core: 2-flop synchroniser, 8N1 RX FSM and bit counter.
// Emits a one-cycle rx_done pulse together with the received byte.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CPB = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic       rx_done,
  output logic [7:0] rx_byte
);

  localparam int CW = $clog2(CPB);
  localparam logic [CW-1:0] FULL = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);

  logic          sync1;
  logic          rxs;
  uart_state_e   state;
  uart_state_e   state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [2:0]    idx;
  logic [2:0]    idx_next;
  logic [7:0]    shift;
  logic [7:0]    shift_next;
  logic          ferr;
  logic          ferr_next;
  logic          done_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxs   <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shift   <= '0;
      ferr    <= 1'b0;
      rx_done <= 1'b0;
      rx_byte <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      idx     <= idx_next;
      shift   <= shift_next;
      ferr    <= ferr_next;
      rx_done <= done_next;
      if (done_next)
        rx_byte <= shift;
    end
  end

  // START samples at the half-bit point so every later sample lands at a bit centre.
  // A low stop bit sets ferr and parks the FSM in STOP until the line returns high.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    shift_next = shift;
    ferr_next  = ferr;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        cnt_next  = '0;
        idx_next  = '0;
        ferr_next = 1'b0;
        if (!rxs)
          state_next = START;
      end
      START: begin
        if (cnt == HALF) begin
          cnt_next   = '0;
          state_next = rxs ? IDLE : DATA;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == FULL) begin
          cnt_next   = '0;
          shift_next = {rxs, shift[7:1]};
          idx_next   = idx + 3'd1;
          if (idx == 3'd7)
            state_next = STOP;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      STOP: begin
        if (ferr) begin
          if (rxs)
            state_next = IDLE;
        end else if (cnt == FULL) begin
          cnt_next = '0;
          if (rxs) begin
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            ferr_next = 1'b1;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: rtl/uart_ctrl.sv
// UART responder for the bridge: strobe edge detection, 8N1 transmitter,
// one-byte receive buffer and status bits. Receive path lives in uart_rx_core.
module uart_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_addr_i,
  input  logic       uart_we_n_i,
  input  logic       uart_re_n_i,
  input  logic [7:0] uart_tx_data_i,
  output logic       uart_tx_ready_o,
  output logic       uart_rx_ready_o,
  output logic [7:0] uart_rx_data_o,
  input  logic       rxd_i,
  output logic       txd_o
);

  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] FULL = CW'(CPB - 1);

  logic          we_q;
  logic          re_q;
  logic          write_evt;
  logic          read_evt;
  uart_state_e   tx_state;
  uart_state_e   tx_state_next;
  logic [CW-1:0] tx_cnt;
  logic [CW-1:0] tx_cnt_next;
  logic [2:0]    tx_idx;
  logic [2:0]    tx_idx_next;
  logic [7:0]    tx_shift;
  logic [7:0]    tx_shift_next;
  logic          txd_next;
  logic          tx_ready_next;
  logic          rx_done;
  logic [7:0]    rx_byte;

  // Events fire only on the falling edge of a strobe and only for the DATA register.
  assign write_evt = ~uart_we_n_i & we_q & ~uart_addr_i;
  assign read_evt  = ~uart_re_n_i & re_q & ~uart_addr_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q <= 1'b1;
      re_q <= 1'b1;
    end else begin
      we_q <= uart_we_n_i;
      re_q <= uart_re_n_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state        <= IDLE;
      tx_cnt          <= '0;
      tx_idx          <= '0;
      tx_shift        <= '0;
      txd_o           <= 1'b1;
      uart_tx_ready_o <= 1'b1;
    end else begin
      tx_state        <= tx_state_next;
      tx_cnt          <= tx_cnt_next;
      tx_idx          <= tx_idx_next;
      tx_shift        <= tx_shift_next;
      txd_o           <= txd_next;
      uart_tx_ready_o <= tx_ready_next;
    end
  end

  // txd is registered, so each state presents the next bit as it hands over.
  always_comb begin
    tx_state_next = tx_state;
    tx_cnt_next   = tx_cnt;
    tx_idx_next   = tx_idx;
    tx_shift_next = tx_shift;
    txd_next      = txd_o;
    tx_ready_next = uart_tx_ready_o;
    case (tx_state)
      IDLE: begin
        txd_next      = 1'b1;
        tx_ready_next = 1'b1;
        tx_cnt_next   = '0;
        if (write_evt) begin
          tx_shift_next = uart_tx_data_i;
          tx_state_next = START;
          txd_next      = 1'b0;
          tx_ready_next = 1'b0;
        end
      end
      START: begin
        if (tx_cnt == FULL) begin
          tx_cnt_next   = '0;
          tx_idx_next   = '0;
          tx_state_next = DATA;
          txd_next      = tx_shift[0];
        end else begin
          tx_cnt_next = tx_cnt + 1'b1;
        end
      end
      DATA: begin
        if (tx_cnt == FULL) begin
          tx_cnt_next   = '0;
          tx_shift_next = tx_shift >> 1;
          if (tx_idx == 3'd7) begin
            tx_state_next = STOP;
            txd_next      = 1'b1;
          end else begin
            tx_idx_next = tx_idx + 3'd1;
            txd_next    = tx_shift[1];
          end
        end else begin
          tx_cnt_next = tx_cnt + 1'b1;
        end
      end
      STOP: begin
        if (tx_cnt == FULL) begin
          tx_cnt_next   = '0;
          tx_state_next = IDLE;
          tx_ready_next = 1'b1;
        end else begin
          tx_cnt_next = tx_cnt + 1'b1;
        end
      end
      default: tx_state_next = IDLE;
    endcase
  end

  uart_rx_core #(
    .CPB(CPB)
  ) u_rx_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .rxd    (rxd_i),
    .rx_done(rx_done),
    .rx_byte(rx_byte)
  );

  // A completing byte takes priority over a simultaneous read (newest data wins).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      uart_rx_ready_o <= 1'b0;
      uart_rx_data_o  <= '0;
    end else if (rx_done) begin
      uart_rx_ready_o <= 1'b1;
      uart_rx_data_o  <= rx_byte;
    end else if (read_evt) begin
      uart_rx_ready_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed self-checking bench for uart_ctrl at 16 clocks per bit: TX framing,
// busy-write drop, RX buffer, overrun, glitch, framing error and mid-frame reset.
module tb_uart_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       addr;
  logic       we_n;
  logic       re_n;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rxd;
  logic       txd;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_ctrl #(
    .CLK_FREQ(160),
    .BAUD    (10)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .uart_addr_i    (addr),
    .uart_we_n_i    (we_n),
    .uart_re_n_i    (re_n),
    .uart_tx_data_i (tx_data),
    .uart_tx_ready_o(tx_ready),
    .uart_rx_ready_o(rx_ready),
    .uart_rx_data_o (rx_data),
    .rxd_i          (rxd),
    .txd_o          (txd)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one full 8N1 frame on rxd (16 cycles per bit), then idles high.
  task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rxd = frame[k];
      tick(16);
    end
    rxd = 1'b1;
  endtask

  task automatic data_read();
    addr = 1'b0;
    re_n = 1'b0;
    tick(1);
    re_n = 1'b1;
  endtask

  initial begin
    logic [9:0] tx_frame;
    rst_n   = 1'b0;
    addr    = 1'b0;
    we_n    = 1'b1;
    re_n    = 1'b1;
    tx_data = 8'h00;
    rxd     = 1'b1;
    tick(2);
    rst_n = 1'b1;
    checkOutput("rst_txd", txd, 1);
    checkOutput("rst_tx_ready", tx_ready, 1);
    checkOutput("rst_rx_ready", rx_ready, 0);
    checkOutput("rst_rx_data", rx_data, 8'h00);
    tick(3);
    checkOutput("idle_txd", txd, 1);
    checkOutput("idle_tx_ready", tx_ready, 1);

    // TX of 0xA5 with a 3-cycle strobe and an ignored busy write at cycle 50
    tx_frame = {1'b1, 8'hA5, 1'b0};
    tx_data  = 8'hA5;
    we_n     = 1'b0;
    for (int i = 0; i < 160; i++) begin
      tick(1);
      checkOutput($sformatf("tx_bit_c%0d", i), txd, tx_frame[i / 16]);
      checkOutput($sformatf("tx_busy_c%0d", i), tx_ready, 0);
      if (i == 2) we_n = 1'b1;
      if (i == 49) begin
        tx_data = 8'h3C;
        we_n    = 1'b0;
      end
      if (i == 50) we_n = 1'b1;
    end
    tick(1);
    checkOutput("tx_done_ready", tx_ready, 1);
    checkOutput("tx_done_txd", txd, 1);
    for (int i = 0; i < 40; i++) begin
      tick(1);
      checkOutput("tx_no_second_frame", txd, 1);
    end

    // RX of 0x5A
    applyStimulus(8'h5A, 1'b1);
    checkOutput("rx_ready_5a", rx_ready, 1);
    checkOutput("rx_data_5a", rx_data, 8'h5A);

    // STATUS read must not consume the byte
    addr = 1'b1;
    re_n = 1'b0;
    tick(3);
    re_n = 1'b1;
    tick(1);
    checkOutput("status_read_keeps", rx_ready, 1);

    // DATA read clears ready, data kept
    addr = 1'b0;
    re_n = 1'b0;
    tick(1);
    checkOutput("data_read_clears", rx_ready, 0);
    checkOutput("data_read_data", rx_data, 8'h5A);
    tick(2);
    re_n = 1'b1;
    tick(1);
    checkOutput("held_read_one_evt", rx_ready, 0);
    data_read();
    tick(1);
    checkOutput("read_empty_ready", rx_ready, 0);
    checkOutput("read_empty_data", rx_data, 8'h5A);

    // Overrun: newest byte wins
    applyStimulus(8'h11, 1'b1);
    checkOutput("ovr_first_data", rx_data, 8'h11);
    applyStimulus(8'h22, 1'b1);
    checkOutput("ovr_ready", rx_ready, 1);
    checkOutput("ovr_data", rx_data, 8'h22);
    data_read();
    tick(1);
    checkOutput("ovr_read_clear", rx_ready, 0);

    // Glitch: 4-cycle low pulse
    rxd = 1'b0;
    tick(4);
    rxd = 1'b1;
    tick(200);
    checkOutput("glitch_ready", rx_ready, 0);
    checkOutput("glitch_data", rx_data, 8'h22);

    // Framing error: stop bit low, then line held low before releasing
    applyStimulus(8'h77, 1'b0);
    checkOutput("ferr_ready", rx_ready, 0);
    checkOutput("ferr_data", rx_data, 8'h22);
    tick(20);
    checkOutput("ferr_ready_late", rx_ready, 0);
    checkOutput("ferr_data_late", rx_data, 8'h22);
    applyStimulus(8'h96, 1'b1);
    checkOutput("ferr_recover_ready", rx_ready, 1);
    checkOutput("ferr_recover_data", rx_data, 8'h96);

    // Reset at cycle 40 of a 0x00 frame (txd low there)
    tx_data = 8'h00;
    we_n    = 1'b0;
    tick(1);
    we_n = 1'b1;
    tick(40);
    checkOutput("mid_tx_txd_low", txd, 0);
    checkOutput("mid_tx_busy", tx_ready, 0);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    checkOutput("mid_rst_txd", txd, 1);
    checkOutput("mid_rst_tx_ready", tx_ready, 1);
    checkOutput("mid_rst_rx_ready", rx_ready, 0);
    checkOutput("mid_rst_rx_data", rx_data, 8'h00);
    tick(20);
    checkOutput("post_rst_txd", txd, 1);
    checkOutput("post_rst_tx_ready", tx_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
